// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS32 execute stage: id/ex register, logic/move ops, HI/LO, ex/mem register.
// Revision : 1.0
// ============================================================================
module ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [7:0]         id_aluop,
    input  logic [2:0]         id_alusel,
    input  logic [DATA_W-1:0]  id_reg1,
    input  logic [DATA_W-1:0]  id_reg2,
    input  logic [RADDR_W-1:0] id_waddr,
    input  logic               id_wr_en,
    output logic               ex_wr_en,
    output logic [RADDR_W-1:0] ex_waddr,
    output logic [DATA_W-1:0]  ex_wdata,
    output logic               mem_wr_en,
    output logic [RADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]  hi_out,
    output logic [DATA_W-1:0]  lo_out
);

    localparam logic [7:0] c_OP_AND  = 8'b0010_0100;
    localparam logic [7:0] c_OP_OR   = 8'b0010_0101;
    localparam logic [7:0] c_OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] c_OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] c_OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] c_OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] c_OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] c_OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] c_OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] c_OP_MTLO = 8'b0001_0011;

    localparam logic [2:0] c_SEL_LOGIC = 3'b001;
    localparam logic [2:0] c_SEL_MOVE  = 3'b011;

    logic [7:0]         r_aluop;
    logic [2:0]         r_alusel;
    logic [DATA_W-1:0]  r_reg1;
    logic [DATA_W-1:0]  r_reg2;
    logic [RADDR_W-1:0] r_waddr;
    logic               r_wr_en;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_mem_wr_en;
    logic [RADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  w_result;

    // id/ex register: flush beats stall so a bubble can be forced while held.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_aluop  <= '0;
            r_alusel <= '0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_waddr  <= '0;
            r_wr_en  <= 1'b0;
        end else if (!stall) begin
            r_aluop  <= id_aluop;
            r_alusel <= id_alusel;
            r_reg1   <= id_reg1;
            r_reg2   <= id_reg2;
            r_waddr  <= id_waddr;
            r_wr_en  <= id_wr_en;
        end
    end

    always_comb begin
        w_result = '0;
        if (r_alusel == c_SEL_LOGIC) begin
            case (r_aluop)
                c_OP_AND: w_result = r_reg1 & r_reg2;
                c_OP_OR:  w_result = r_reg1 | r_reg2;
                c_OP_XOR: w_result = r_reg1 ^ r_reg2;
                c_OP_NOR: w_result = ~(r_reg1 | r_reg2);
                default:  w_result = '0;
            endcase
        end else if (r_alusel == c_SEL_MOVE) begin
            case (r_aluop)
                c_OP_MFHI: w_result = r_hi;
                c_OP_MFLO: w_result = r_lo;
                c_OP_MOVZ,
                c_OP_MOVN: w_result = r_reg1;
                default:   w_result = '0;
            endcase
        end
    end

    // A following MFHI/MFLO reads the register directly, so the write lands first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!stall) begin
            if (r_aluop == c_OP_MTHI) r_hi <= r_reg1;
            if (r_aluop == c_OP_MTLO) r_lo <= r_reg1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stall) begin
            r_mem_wr_en <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_wr_en <= r_wr_en;
            r_mem_waddr <= r_waddr;
            r_mem_wdata <= w_result;
        end
    end

    assign ex_wr_en  = r_wr_en;
    assign ex_waddr  = r_waddr;
    assign ex_wdata  = w_result;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

endmodule
`default_nettype wire
